// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multicycle fetch/decode/execute sequencer for the 16-bit
// von Neumann CPU. Owns the shared memory port (REQ/ACK) and the PC, IR, DR
// and AC registers. It feeds the external ALU from AC/DR/IR[14:13] and
// captures the ALU result back into AC.
//
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   o_mem_req/o_mem_we       memory request and write enable (registered)
//   o_mem_addr/o_mem_wdata   word address and write data (write data is AC)
//   i_mem_rdata/i_mem_ack    read data and transfer-complete strobe
//   o_alu_a/o_alu_b/o_alu_fun  ALU operands (AC, DR) and function (IR[14:13])
//   i_alu_z                  combinational ALU result
//   o_pc_out/o_ac_out        debug views of PC and AC
//   o_ac_zero                high while AC == 0
//   o_halted                 high while in HALT
module cpu_control_unit #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [11:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic [15:0] o_alu_a,
    output logic [15:0] o_alu_b,
    output logic [1:0]  o_alu_fun,
    input  logic [15:0] i_alu_z,
    output logic [11:0] o_pc_out,
    output logic [15:0] o_ac_out,
    output logic        o_ac_zero,
    output logic        o_halted
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 12;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_STA = 3'b101;
    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WRITE,
        S_HALT
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_ir;
    logic [DATA_W-1:0]   r_dr;
    logic [DATA_W-1:0]   r_ac;
    logic                r_ac_zero;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_halted;

    logic [2:0]          w_opcode;
    logic [ADDR_W-1:0]   w_ir_addr;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic                w_jmp_take;
    logic [DATA_W-1:0]   w_exec_res;
    logic                w_xfer_done;

    assign w_opcode    = r_ir[15:13];
    assign w_ir_addr   = r_ir[ADDR_W-1:0];
    assign w_pc_inc    = r_pc + ADDR_W'(1);
    assign w_jmp_take  = ~r_ir[12] | r_ac_zero;
    assign w_exec_res  = (w_opcode == OP_LDA) ? r_dr : i_alu_z;
    // ACK only counts while a request is actually outstanding
    assign w_xfer_done = r_mem_req & i_mem_ack;

    // Sequencer: state, architectural registers and registered memory port.
    // The memory port registers are loaded with the values the next state
    // needs, so REQ/ADDR/WE are already valid on entry to a memory state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_dr       <= '0;
            r_ac       <= '0;
            r_ac_zero  <= 1'b1;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= RESET_PC;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_xfer_done) begin
                        r_ir       <= i_mem_rdata;
                        r_pc       <= w_pc_inc;
                        r_mem_req  <= 1'b0;
                        r_mem_addr <= w_pc_inc;
                        r_state    <= S_DECODE;
                    end else begin
                        // first cycle after reset raises the fetch request
                        r_mem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    case (w_opcode)
                        OP_ADD, OP_AND, OP_LDA: begin
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= w_ir_addr;
                            r_state    <= S_READ;
                        end
                        OP_NOT, OP_SHR: begin
                            r_state <= S_EXEC;
                        end
                        OP_STA: begin
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= w_ir_addr;
                            r_state    <= S_WRITE;
                        end
                        OP_JMP: begin
                            if (w_jmp_take) begin
                                r_pc       <= w_ir_addr;
                                r_mem_addr <= w_ir_addr;
                            end
                            r_mem_req <= 1'b1;
                            r_state   <= S_FETCH;
                        end
                        OP_HLT: begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
                        default: begin
                            r_state <= S_DECODE;
                        end
                    endcase
                end
                S_READ: begin
                    if (w_xfer_done) begin
                        r_dr       <= i_mem_rdata;
                        r_mem_req  <= 1'b0;
                        r_mem_addr <= r_pc;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_ac      <= w_exec_res;
                    r_ac_zero <= (w_exec_res == DATA_W'(0));
                    r_mem_req <= 1'b1;
                    r_state   <= S_FETCH;
                end
                S_WRITE: begin
                    // REQ stays high: the next fetch starts immediately
                    if (w_xfer_done) begin
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_pc;
                        r_state    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_mem_req <= 1'b0;
                    r_halted  <= 1'b1;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_ac;
    assign o_alu_a     = r_ac;
    assign o_alu_b     = r_dr;
    assign o_alu_fun   = r_ir[14:13];
    assign o_pc_out    = r_pc;
    assign o_ac_out    = r_ac;
    assign o_ac_zero   = r_ac_zero;
    assign o_halted    = r_halted;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Testbench for cpu_control_unit: behavioural memory with programmable wait
// states, behavioural ALU, table of single-instruction programs and a few
// hand-written multi-cycle sequences.
module tb_cpu_control_unit;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_fun;
    logic [15:0] alu_z;
    logic [11:0] pc_out;
    logic [15:0] ac_out;
    logic        ac_zero;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem [4096];
    int          wait_n = 0;
    int          wcnt;
    int          wr_cnt;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;

    cpu_control_unit #(.RESET_PC(12'h000)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ack   (mem_ack),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_fun   (alu_fun),
        .i_alu_z     (alu_z),
        .o_pc_out    (pc_out),
        .o_ac_out    (ac_out),
        .o_ac_zero   (ac_zero),
        .o_halted    (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory: ACK after wait_n wait cycles, reads combinational
    assign mem_ack   = mem_req && (wcnt >= wait_n);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    // record DUT writes (memory array itself is only loaded by the test)
    initial wr_cnt = 0;
    always @(posedge clk) begin
        if (mem_req && mem_ack && mem_we) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
    end

    // ALU model
    always_comb begin
        case (alu_fun)
            2'b00:   alu_z = alu_a + alu_b;
            2'b01:   alu_z = alu_a & alu_b;
            2'b10:   alu_z = ~alu_a;
            default: alu_z = alu_a >> 1;
        endcase
    end

    typedef struct packed {
        logic [15:0] init_ac;
        logic [15:0] instr;
        logic [15:0] operand;
        logic [15:0] exp_ac;
        logic [11:0] exp_pc;
        logic [7:0]  exp_cyc;
        logic        exp_wr;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fill_halt();
        for (int a = 0; a < 4096; a++) mem[a] = 16'hE000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // cycles from the edge raising the first REQ to the edge raising HALTED
    task automatic run_to_halt(input int maxc, output int cyc);
        int  c;
        bit  started;
        c = 0;
        started = 1'b0;
        cyc = -1;
        for (int k = 0; k < maxc; k++) begin
            @(posedge clk);
            #1;
            if (!started) begin
                if (mem_req) started = 1'b1;
            end else begin
                c++;
                if (halted) begin
                    cyc = c;
                    break;
                end
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          cyc;
        int          wr0;
        int          n_log;
        int          viol;
        int          waits;
        bit          any_req;
        bit          p_req, p_ack, p_we, found;
        logic [11:0] p_addr;
        logic [15:0] p_wdata;
        logic [15:0] prev_ac;
        logic [1:0]  prev_fun;
        logic [15:0] log_ac  [4];
        logic [1:0]  log_fun [4];

        // LDA 100 ; <instr with operand at 101> ; HLT
        vecs[0]  = '{16'h1234, 16'h0065, 16'h1111, 16'h2345, 12'h003, 8'd10, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0065, 16'h0002, 16'h0001, 12'h003, 8'd10, 1'b0};
        vecs[2]  = '{16'hA5A5, 16'h2065, 16'h0F0F, 16'h0505, 12'h003, 8'd10, 1'b0};
        vecs[3]  = '{16'hA5A5, 16'h4000, 16'h0000, 16'h5A5A, 12'h003, 8'd9,  1'b0};
        vecs[4]  = '{16'hA5A5, 16'h6000, 16'h0000, 16'h52D2, 12'h003, 8'd9,  1'b0};
        vecs[5]  = '{16'h8001, 16'h6000, 16'h0000, 16'h4000, 12'h003, 8'd9,  1'b0};
        vecs[6]  = '{16'h1234, 16'h8065, 16'hBEEF, 16'hBEEF, 12'h003, 8'd10, 1'b0};
        vecs[7]  = '{16'h1357, 16'hA066, 16'h0000, 16'h1357, 12'h003, 8'd9,  1'b1};
        vecs[8]  = '{16'h0000, 16'hD020, 16'h0000, 16'h0000, 12'h021, 8'd8,  1'b0};
        vecs[9]  = '{16'h0001, 16'hD020, 16'h0000, 16'h0001, 12'h003, 8'd8,  1'b0};
        vecs[10] = '{16'h0005, 16'hCFFF, 16'h0000, 16'h0005, 12'h000, 8'd8,  1'b0};
        vecs[11] = '{16'h0005, 16'hC020, 16'h0000, 16'h0005, 12'h021, 8'd8,  1'b0};

        rst = 1'b1;
        wait_n = 0;
        fill_halt();

        // reset state and first fetch with M[0] = HLT
        repeat (2) @(negedge clk);
        check("rst_req",     32'(mem_req), 32'd0);
        check("rst_we",      32'(mem_we),  32'd0);
        check("rst_halted",  32'(halted),  32'd0);
        check("rst_pc",      32'(pc_out),  32'h000);
        check("rst_ac",      32'(ac_out),  32'h0000);
        check("rst_ac_zero", 32'(ac_zero), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("first_req",  32'(mem_req),  32'd1);
        check("first_addr", 32'(mem_addr), 32'h000);
        check("first_we",   32'(mem_we),   32'd0);
        @(posedge clk); #1;
        check("hlt_not_yet", 32'(halted), 32'd0);
        @(posedge clk); #1;
        check("hlt_halted", 32'(halted), 32'd1);
        check("hlt_pc",     32'(pc_out), 32'h001);
        any_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            any_req = any_req | mem_req;
        end
        check("hlt_req_low", 32'(any_req), 32'd0);

        // single-instruction table
        for (int i = 0; i < 12; i++) begin
            fill_halt();
            mem[12'h000] = 16'h8064;
            mem[12'h001] = vecs[i].instr;
            mem[12'h064] = vecs[i].init_ac;
            mem[12'h065] = vecs[i].operand;
            wr0 = wr_cnt;
            do_reset();
            run_to_halt(200, cyc);
            check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            check($sformatf("vec%0d_ac", i), 32'(ac_out), 32'(vecs[i].exp_ac));
            check($sformatf("vec%0d_pc", i), 32'(pc_out), 32'(vecs[i].exp_pc));
            check($sformatf("vec%0d_ac_zero", i), 32'(ac_zero), 32'(vecs[i].exp_ac == 16'h0000));
            check($sformatf("vec%0d_writes", i), 32'(wr_cnt - wr0), 32'(vecs[i].exp_wr));
            if (vecs[i].exp_wr) begin
                check($sformatf("vec%0d_wr_addr", i), 32'(wr_addr), 32'h066);
                check($sformatf("vec%0d_wr_data", i), 32'(wr_data), 32'(vecs[i].init_ac));
            end
        end

        // arithmetic program, zero-wait
        fill_halt();
        mem[0] = 16'h800A; mem[1] = 16'h000B; mem[2] = 16'hA00C; mem[3] = 16'hE000;
        mem[10] = 16'hFFFF; mem[11] = 16'h0002;
        do_reset();
        run_to_halt(200, cyc);
        check("arith_cycles",  32'(cyc),     32'd13);
        check("arith_wr_addr", 32'(wr_addr), 32'h00C);
        check("arith_wr_data", 32'(wr_data), 32'h0001);

        // NOT / SHR / AND chain with ALU function log
        fill_halt();
        mem[0] = 16'h800A; mem[1] = 16'h4000; mem[2] = 16'h6000; mem[3] = 16'h200B;
        mem[4] = 16'hE000; mem[10] = 16'hA5A5; mem[11] = 16'h0F0F;
        do_reset();
        n_log = 0;
        prev_ac = ac_out;
        prev_fun = alu_fun;
        for (int k = 0; k < 100 && !halted; k++) begin
            @(negedge clk);
            if (ac_out != prev_ac && n_log < 4) begin
                log_ac[n_log]  = ac_out;
                log_fun[n_log] = prev_fun;
                n_log++;
            end
            prev_ac = ac_out;
            prev_fun = alu_fun;
        end
        check("chain_halted", 32'(halted), 32'd1);
        check("chain_n",      32'(n_log),  32'd4);
        check("chain_not_ac", 32'(log_ac[1]),  32'h5A5A);
        check("chain_shr_ac", 32'(log_ac[2]),  32'h2D2D);
        check("chain_and_ac", 32'(log_ac[3]),  32'h0D0D);
        check("chain_not_fun", 32'(log_fun[1]), 32'd2);
        check("chain_shr_fun", 32'(log_fun[2]), 32'd3);
        check("chain_and_fun", 32'(log_fun[3]), 32'd1);

        // arithmetic program with 3 wait states per access
        fill_halt();
        mem[0] = 16'h800A; mem[1] = 16'h000B; mem[2] = 16'hA00C; mem[3] = 16'hE000;
        mem[10] = 16'hFFFF; mem[11] = 16'h0002;
        wait_n = 3;
        do_reset();
        viol = 0; waits = 0; cyc = -1; found = 1'b0;
        p_req = 1'b0; p_ack = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (found) cyc++;
            if (!found && mem_req) begin
                found = 1'b1;
                cyc = 0;
            end
            if (p_req && !p_ack) begin
                waits++;
                if (!mem_req || mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wdata)
                    viol++;
            end
            p_req = mem_req; p_ack = mem_ack; p_we = mem_we;
            p_addr = mem_addr; p_wdata = mem_wdata;
            if (halted) break;
        end
        check("wait_halted",  32'(halted),  32'd1);
        check("wait_cycles",  32'(cyc),     32'd34);
        check("wait_count",   32'(waits),   32'd21);
        check("wait_stable",  32'(viol),    32'd0);
        check("wait_wr_data", 32'(wr_data), 32'h0001);

        // reset during a READ wait
        fill_halt();
        mem[0] = 16'h800A; mem[1] = 16'h000B; mem[2] = 16'hE000;
        mem[10] = 16'hA5A5; mem[11] = 16'h0002;
        wait_n = 3;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (mem_req && !mem_we && mem_addr == 12'h00B) found = 1'b1;
        end
        check("rstr_found", 32'(found), 32'd1);
        @(negedge clk);
        check("rstr_pre_ac", 32'(ac_out), 32'hA5A5);
        rst = 1'b1;
        #1;
        check("rstr_req", 32'(mem_req), 32'd0);
        check("rstr_ac",  32'(ac_out),  32'h0000);
        check("rstr_pc",  32'(pc_out),  32'h000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rstr_refetch_req",  32'(mem_req),  32'd1);
        check("rstr_refetch_addr", 32'(mem_addr), 32'h000);
        run_to_halt(200, cyc);
        check("rstr_final_ac", 32'(ac_out), 32'hA5A7);
        check("rstr_final_pc", 32'(pc_out), 32'h003);

        // reset during EXEC of LDA
        fill_halt();
        mem[0] = 16'h800A; mem[1] = 16'hE000; mem[10] = 16'hA5A5;
        wait_n = 0;
        do_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rste_pre_req", 32'(mem_req), 32'd0);
        check("rste_pre_pc",  32'(pc_out),  32'h001);
        rst = 1'b1;
        #1;
        check("rste_req", 32'(mem_req), 32'd0);
        check("rste_ac",  32'(ac_out),  32'h0000);
        check("rste_pc",  32'(pc_out),  32'h000);
        @(negedge clk);
        rst = 1'b0;
        run_to_halt(200, cyc);
        check("rste_cycles",   32'(cyc),    32'd6);
        check("rste_final_ac", 32'(ac_out), 32'hA5A5);
        check("rste_final_pc", 32'(pc_out), 32'h002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
